// File: rtl/dm_bytelane_if.sv
// Request/response bundle between the MEM stage and the dm_bytelane data memory.
interface dm_bytelane_if;
    logic        req;
    logic        DMWr;
    logic [2:0]  DMType;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] pc;
    logic [31:0] dout;
    logic        ready;
    logic        err;

    modport master (
        output req, DMWr, DMType, addr, din, pc,
        input  dout, ready, err
    );

    modport slave (
        input  req, DMWr, DMType, addr, din, pc,
        output dout, ready, err
    );
endinterface

// File: rtl/dm_bytelane.sv
// Handshaked byte-lane data memory with wait states and misalignment flagging.
// Optional store trace to the simulator console: define DM_TRACE_EN.
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on accept
// WAIT   | counting down WAIT_CYCLES wait states
// DONE   | ready pulse; store/load committed on the edge entering this state
module dm_bytelane #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    dm_bytelane_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [2:0] LP_WLOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic        r_wr;
    logic [2:0]  r_type;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic [31:0] r_pc;
    logic [31:0] r_dout;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_done;
    logic                  w_wr;
    logic [2:0]            w_type;
    logic [31:0]           w_addr;
    logic [31:0]           w_din;
    logic [31:0]           w_pc;
    logic                  w_is_half;
    logic                  w_is_byte;
    logic                  w_misal;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_rword;
    logic [31:0]           w_merged;
    logic [31:0]           w_load;
    logic [7:0]            w_lane_b;
    logic [15:0]           w_lane_h;
    logic                  w_unused;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
            S_WAIT:  if (r_cnt == 3'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept     = (r_state == S_IDLE) && bus.req;
    assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE) && !rst;

    // With zero wait states the commit edge is also the accept edge, so use the live bus fields then.
    assign w_wr   = (r_state == S_IDLE) ? bus.DMWr   : r_wr;
    assign w_type = (r_state == S_IDLE) ? bus.DMType : r_type;
    assign w_addr = (r_state == S_IDLE) ? bus.addr   : r_addr;
    assign w_din  = (r_state == S_IDLE) ? bus.din    : r_din;
    assign w_pc   = (r_state == S_IDLE) ? bus.pc     : r_pc;

    assign w_is_half = (w_type == 3'b001) || (w_type == 3'b010);
    assign w_is_byte = (w_type == 3'b011) || (w_type == 3'b100);
    assign w_misal   = w_is_half ? w_addr[0] :
                       w_is_byte ? 1'b0 : (w_addr[1:0] != 2'b00);
    assign w_idx     = w_addr[ADDR_WIDTH+1:2];
    assign w_rword   = r_mem[w_idx];
    assign w_lane_b  = w_rword[{w_addr[1:0], 3'b000} +: 8];
    assign w_lane_h  = w_rword[{w_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_merged = w_rword;
        if (w_is_byte)
            w_merged[{w_addr[1:0], 3'b000} +: 8] = w_din[7:0];
        else if (w_is_half)
            w_merged[{w_addr[1], 4'b0000} +: 16] = w_din[15:0];
        else
            w_merged = w_din;
    end

    always_comb begin
        w_load = w_rword;
        case (w_type)
            3'b001:  w_load = {{16{w_lane_h[15]}}, w_lane_h};
            3'b010:  w_load = {16'h0000, w_lane_h};
            3'b011:  w_load = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_load = {24'h000000, w_lane_b};
            default: w_load = w_rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_wr    <= 1'b0;
            r_type  <= 3'd0;
            r_addr  <= 32'd0;
            r_din   <= 32'd0;
            r_pc    <= 32'd0;
            r_dout  <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_wr   <= bus.DMWr;
                r_type <= bus.DMType;
                r_addr <= bus.addr;
                r_din  <= bus.din;
                r_pc   <= bus.pc;
                r_cnt  <= LP_WLOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_enter_done) begin
                r_err <= w_misal;
                if (w_misal)
                    r_dout <= 32'd0;
                else if (!w_wr)
                    r_dout <= w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enter_done && w_wr && !w_misal)
            r_mem[w_idx] <= w_merged;
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (w_enter_done && w_wr) begin
            if (w_misal)
                $display("misaligned store: pc = %h, addr = %h", w_pc, w_addr);
            else
                $display("pc = %h: dataaddr = %h, memdata = %h", w_pc, {w_addr[31:2], 2'b00}, w_merged);
        end
    end
`endif

    assign w_unused = ^{w_pc, w_addr[31:ADDR_WIDTH+2]};

    assign bus.ready = (r_state == S_DONE);
    assign bus.err   = r_err;
    assign bus.dout  = r_dout;
endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane: zero-wait instance for data paths, three-wait instance for timing and reset.
module tb_dm_bytelane;
    logic clk;
    logic rst0;
    logic rst3;
    int   n_checks;
    int   n_err;

    dm_bytelane_if if0 ();
    dm_bytelane_if if3 ();

    dm_bytelane #(.ADDR_WIDTH(7), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0));
    dm_bytelane #(.ADDR_WIDTH(7), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          wr;
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
        bit          chk;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input bit w);
        return w ? if3.ready : if0.ready;
    endfunction

    task automatic drive(input bit w, input bit rq, input bit wr, input logic [2:0] ty,
                         input logic [31:0] a, input logic [31:0] d);
        if (w) begin
            if3.req = rq; if3.DMWr = wr; if3.DMType = ty; if3.addr = a; if3.din = d; if3.pc = 32'h1000 + a;
        end else begin
            if0.req = rq; if0.DMWr = wr; if0.DMType = ty; if0.addr = a; if0.din = d; if0.pc = 32'h1000 + a;
        end
    endtask

    task automatic set_req(input bit w, input bit v);
        if (w) if3.req = v;
        else   if0.req = v;
    endtask

    // One request: returns cycles from accept edge to ready, response fields, and whether ready dropped after one cycle.
    task automatic access(input bit w, input bit wr, input logic [2:0] ty, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] dq,
                          output logic e, output bit pulse_ok);
        @(negedge clk);
        drive(w, 1'b1, wr, ty, a, d);
        @(negedge clk);
        set_req(w, 1'b0);
        lat = 1;
        while (!rdy(w) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dq = w ? if3.dout : if0.dout;
        e  = w ? if3.err  : if0.err;
        @(negedge clk);
        pulse_ok = !rdy(w);
    endtask

    initial begin
        int          lat;
        logic [31:0] dq;
        logic        e;
        bit          pok;
        int          pulses;
        int          first_rdy;
        logic [31:0] cap;

        n_checks = 0;
        n_err    = 0;
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        vecs.push_back('{1'b1, 3'b000, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h020, 32'h11223344, 32'hDEADBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 3'b011, 32'h021, 32'h000000AA, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'b001, 32'h022, 32'h0000BEEF, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h020, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h021, 32'h0,        32'hFFFFFFAA, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h021, 32'h0,        32'h000000AA, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h022, 32'h0,        32'hFFFFBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h022, 32'h0,        32'h0000BEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h020, 32'h0,        32'h00000044, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b100, 32'h013, 32'h0,        32'h000000DE, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h010, 32'h0,        32'hFFFFBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b010, 32'h012, 32'h0,        32'h0000DEAD, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b101, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h030, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'b000, 32'h031, 32'h12345678, 32'h0,        1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'b001, 32'h031, 32'h0000FFFF, 32'h0,        1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'b000, 32'h030, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b001, 32'h033, 32'h0,        32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 3'b000, 32'h200, 32'h12345678, 32'h0,        1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h000, 32'h0,        32'h12345678, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b011, 32'h002, 32'h0,        32'h00000034, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'b000, 32'h031, 32'h0,        32'h00000000, 1'b1, 1'b1});

        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);
        check("rst_ready0", 32'(if0.ready), 32'd0);
        check("rst_err0",   32'(if0.err),   32'd0);
        check("rst_dout0",  if0.dout,       32'd0);
        check("rst_ready3", 32'(if3.ready), 32'd0);
        check("rst_dout3",  if3.dout,       32'd0);

        // Request coinciding with reset must not be accepted.
        @(negedge clk);
        rst0 = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        rst0 = 1'b0;
        set_req(1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if0.ready) pulses++;
        end
        check("req_with_rst_pulses", 32'(pulses), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            access(1'b0, vecs[i].wr, vecs[i].ty, vecs[i].addr, vecs[i].din, lat, dq, e, pok);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_pulse", i), 32'(pok), 32'd1);
            if (vecs[i].chk)
                check($sformatf("vec%0d_dout", i), dq, vecs[i].exp);
        end

        // Wait-state instance: latency and one-cycle pulse.
        access(1'b1, 1'b1, 3'b000, 32'h040, 32'h0BADF00D, lat, dq, e, pok);
        check("ws_store_latency", 32'(lat), 32'd4);
        check("ws_store_err", 32'(e), 32'd0);
        check("ws_store_pulse", 32'(pok), 32'd1);

        // req held high through WAIT is ignored: exactly one ready.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h040, 32'h0);
        pulses = 0;
        first_rdy = -1;
        cap = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) set_req(1'b1, 1'b0);
            if (if3.ready) begin
                pulses++;
                if (first_rdy < 0) begin
                    first_rdy = i;
                    cap = if3.dout;
                end
            end
        end
        check("ws_ignore_pulses", 32'(pulses), 32'd1);
        check("ws_ignore_latency", 32'(first_rdy + 1), 32'd4);
        check("ws_ignore_dout", cap, 32'h0BADF00D);

        // Reset two cycles after accept drops the store.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 32'h040, 32'h00000055);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_req(1'b1, 1'b0);
            rst3 = (i == 1);
            if (if3.ready) pulses++;
        end
        check("rst_mid_pulses", 32'(pulses), 32'd0);
        check("rst_mid_dout", if3.dout, 32'd0);

        // Reset on the DONE-entry edge also suppresses the write.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 32'h040, 32'h00000066);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_req(1'b1, 1'b0);
            rst3 = (i == 2);
            if (if3.ready) pulses++;
        end
        check("rst_done_edge_pulses", 32'(pulses), 32'd0);

        access(1'b1, 1'b0, 3'b000, 32'h040, 32'h0, lat, dq, e, pok);
        check("rst_after_load_dout", dq, 32'h0BADF00D);
        check("rst_after_load_latency", 32'(lat), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
